// File: rtl/cpu_step_pkg.sv
// -----------------------------------------------------------------------------
// cpu_step_pkg
// Shared definitions for the CPU step/run controller: state encoding and the
// default timing parameters (divider period and debounce length at 50 MHz).
// -----------------------------------------------------------------------------
package cpu_step_pkg;

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2,
        ST_BREAK   = 2'd3
    } cpu_state_t;

    // 2 Hz run rate from a 50 MHz clock
    localparam int DIV_DEFAULT     = 25000000;
    // 20 ms of stable level at 50 MHz
    localparam int DEB_CYC_DEFAULT = 1000000;

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes a raw active-low pushbutton, debounces it and emits a single
// one-cycle event per press.
//   iCLK      : clock
//   iRST_N    : asynchronous active-low reset (debouncer comes up released)
//   raw_n     : raw asynchronous pushbutton, active-low
//   press_evt : one-cycle pulse when the debounced level falls to pressed
// The debounced level only flips after DEB_CYC consecutive samples that
// disagree with it, so a new press can only be seen after an equally long
// released period.
// -----------------------------------------------------------------------------
module key_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic raw_n,
    output logic press_evt
);

    localparam int CNT_W = $clog2(DEB_CYC);

    logic             sync_1;
    logic             sync_2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_1    <= 1'b1;
            sync_2    <= 1'b1;
            level     <= 1'b1;
            cnt       <= '0;
            press_evt <= 1'b0;
        end else begin
            sync_1    <= raw_n;
            sync_2    <= sync_1;
            press_evt <= 1'b0;
            if (sync_2 != level) begin
                // count consecutive disagreeing samples; flip on the last one
                if (cnt == CNT_W'(DEB_CYC - 1)) begin
                    level     <= sync_2;
                    cnt       <= '0;
                    press_evt <= ~sync_2;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_step_ctrl
// Run/step controller producing the one-cycle CPU clock-enable.
//   iCLK     : single clock
//   iRST_N   : asynchronous active-low reset
//   iRUN     : async slide switch, 1 = free run
//   iSTEP_N  : async raw pushbutton, active-low, one step per press
//   iPC      : current datapath PC
//   iBP_ARM  : breakpoint armed
//   iBP_ADDR : breakpoint PC
//   oCPU_EN  : registered one-cycle enable for PC / register file / I/O write
//   oSTATE   : registered current state (HALTED/RUNNING/STEP/BREAK)
//   oCYCLES  : count of issued enable pulses, wraps at 16 bits
// Optional feature: define CPU_STEP_BREAKPOINT_EN to enable the PC breakpoint
// (BREAK state). Without it BREAK is never entered and the breakpoint inputs
// are ignored.
// -----------------------------------------------------------------------------
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int DIV     = DIV_DEFAULT,
    parameter int DEB_CYC = DEB_CYC_DEFAULT
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iRUN,
    input  logic        iSTEP_N,
    input  logic [7:0]  iPC,
    input  logic        iBP_ARM,
    input  logic [7:0]  iBP_ADDR,
    output logic        oCPU_EN,
    output logic [1:0]  oSTATE,
    output logic [15:0] oCYCLES
);

    localparam int DIV_W = $clog2(DIV);

    logic             run_s1;
    logic             run_s2;
    logic             step_evt;
    cpu_state_t       state;
    logic [DIV_W-1:0] div_cnt;
    logic             div_tc;
    logic             cpu_en;
    logic [15:0]      cycles;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_s1 <= 1'b0;
            run_s2 <= 1'b0;
        end else begin
            run_s1 <= iRUN;
            run_s2 <= run_s1;
        end
    end

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_step_deb (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .raw_n     (iSTEP_N),
        .press_evt (step_evt)
    );

    assign div_tc = (div_cnt == DIV_W'(DIV - 1));

`ifdef CPU_STEP_BREAKPOINT_EN
    logic bp_hit;
    assign bp_hit = iBP_ARM && (iPC == iBP_ADDR);
`else
    logic unused_bp;
    assign unused_bp = ^{iPC, iBP_ARM, iBP_ADDR};
`endif

    // Outputs are registered: the enable is raised in the same edge that
    // enters STEP or hits the divider terminal count, and cleared by default.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= ST_HALTED;
            div_cnt <= '0;
            cpu_en  <= 1'b0;
            cycles  <= '0;
        end else begin
            cpu_en <= 1'b0;
            case (state)
                ST_HALTED: begin
                    if (run_s2) begin
                        state   <= ST_RUNNING;
                        div_cnt <= '0;
                    end else if (step_evt) begin
                        state  <= ST_STEP;
                        cpu_en <= 1'b1;
                        cycles <= cycles + 16'd1;
                    end
                end
                ST_STEP: begin
                    state <= ST_HALTED;
                end
                ST_RUNNING: begin
                    // leaving takes priority over a terminal-count pulse;
                    // the divider simply holds while halted
                    if (!run_s2) begin
                        state <= ST_HALTED;
                    end else if (div_tc) begin
                        div_cnt <= '0;
`ifdef CPU_STEP_BREAKPOINT_EN
                        if (bp_hit) begin
                            state <= ST_BREAK;
                        end else begin
                            cpu_en <= 1'b1;
                            cycles <= cycles + 16'd1;
                        end
`else
                        cpu_en <= 1'b1;
                        cycles <= cycles + 16'd1;
`endif
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_BREAK: begin
`ifdef CPU_STEP_BREAKPOINT_EN
                    if (step_evt) begin
                        state  <= ST_STEP;
                        cpu_en <= 1'b1;
                        cycles <= cycles + 16'd1;
                    end else if (!run_s2) begin
                        state <= ST_HALTED;
                    end
`else
                    state <= ST_HALTED;
`endif
                end
                default: begin
                    state <= ST_HALTED;
                end
            endcase
        end
    end

    assign oCPU_EN = cpu_en;
    assign oSTATE  = state;
    assign oCYCLES = cycles;

endmodule
